// File: rtl/jtkicker_psg_wrif.sv
// jtkicker_psg_wrif: SN76489 bus write decoder with READY handshake and register file
// One instance per PSG; feeds the tone/noise generators.
module jtkicker_psg_wrif #(
    parameter int READY_CYC = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       ce_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic       ready,
    output logic [9:0] tone0,
    output logic [9:0] tone1,
    output logic [9:0] tone2,
    output logic [3:0] vol0,
    output logic [3:0] vol1,
    output logic [3:0] vol2,
    output logic [3:0] vol3,
    output logic [2:0] noise_ctl,
    output logic       noise_rst
);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
    state_t state, state_nx;
    logic [7:0] cnt;
    logic [2:0] latch, tgt;
    logic [9:0] tone [3];
    logic [3:0] vol [4];
    logic accept;

    assign accept = clk_en && state == IDLE && !ce_n && !wr_n;
    // {ch, type}: a latch byte names its own target, a data byte reuses the last latch
    assign tgt = din[7] ? din[6:4] : latch;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else if (clk_en) state <= state_nx;
    end

    // HOLD waits for ce_n release so the same CPU cycle cannot trigger twice
    always_comb begin
        state_nx = state == IDLE ? ((!ce_n && !wr_n) ? BUSY : IDLE) :
                   state == BUSY ? ((cnt == 8'd0) ? HOLD : BUSY) :
                   (ce_n ? IDLE : HOLD);
    end

    always_comb begin
        ready = state != BUSY;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (clk_en) cnt <= accept ? 8'(READY_CYC - 1) : (cnt != 8'd0 ? cnt - 8'd1 : cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latch     <= '0;
            noise_ctl <= '0;
            noise_rst <= 1'b0;
            for (int i = 0; i < 3; i++) tone[i] <= '0;
            for (int i = 0; i < 4; i++) vol[i] <= 4'hF;
        end else begin
            noise_rst <= accept && tgt == 3'b110;
            if (accept) begin
                if (din[7]) latch <= din[6:4];
                if (tgt[0]) vol[tgt[2:1]] <= din[3:0];
                else if (tgt[2:1] == 2'd3) noise_ctl <= din[2:0];
                else if (din[7]) tone[tgt[2:1]][3:0] <= din[3:0];
                else tone[tgt[2:1]][9:4] <= din[5:0];
            end
        end
    end

    assign tone0 = tone[0];
    assign tone1 = tone[1];
    assign tone2 = tone[2];
    assign vol0  = vol[0];
    assign vol1  = vol[1];
    assign vol2  = vol[2];
    assign vol3  = vol[3];
endmodule
